// File: rtl/motion_pkg.sv
// Shared motion-core definitions used by the timing calculator arbiter.
// Holds the axis-count default, operand width, ramp parameter slot indices
// and the arbiter state encoding.
package motion_pkg;

   localparam int NUM_AXES_DEF = 4;
   localparam int CALC_W       = 32;
   localparam int NUM_PARAMS   = 5;

   // Slot indices into the packed five-entry ramp parameter vector
   localparam int PARAM_N      = 0;
   localparam int PARAM_NN     = 1;
   localparam int PARAM_T0     = 2;
   localparam int PARAM_TNA    = 3;
   localparam int PARAM_DELTA  = 4;

   typedef enum logic [2:0] {
      ARB_IDLE   = 3'd0,
      ARB_BUSY   = 3'd1,
      ARB_DONE   = 3'd2,
      ARB_DRAIN  = 3'd3,
      ARB_REJECT = 3'd4
   } arb_state_t;

endpackage

// File: rtl/timing_calc_arbiter_rr.sv
// Combinational round-robin pick.
// Ports:
//   req       - per-axis request levels
//   rr_ptr    - axis with highest priority this cycle
//   grant     - one-hot winner (all zero when nothing is requested)
//   grant_idx - index of the winner
//   grant_vld - at least one request present
module rr_arbiter #(
   parameter int NUM_AXES = 4,
   parameter int IDX_W    = 2
) (
   input  logic [NUM_AXES-1:0] req,
   input  logic [IDX_W-1:0]    rr_ptr,
   output logic [NUM_AXES-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                grant_vld
);

   always_comb begin
      int sum;
      logic [IDX_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      sum       = 0;
      idx       = '0;
      // Walk upward from rr_ptr with wrap; the first hit wins
      for (int off = 0; off < NUM_AXES; off++) begin
         sum = int'(rr_ptr) + off;
         if (sum >= NUM_AXES) sum = sum - NUM_AXES;
         idx = IDX_W'(sum);
         if (!grant_vld && req[idx]) begin
            grant_vld  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/timing_calc_arbiter.sv
// Shares one speed_to_timing calculator between the axis controllers.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   req                   - per-axis request level, held until ack/err
//   req_num/speed/acc/jerk- packed per-axis operands, axis i at [32*i +: 32]
//   ack, err              - one-cycle per-axis result / rejection pulses
//   res_params, res_axis  - latched ramp parameters and their owner axis
//   busy                  - arbiter not idle
//   calc_*                - start level, operands and results of the calculator
module timing_calc_arbiter
   import motion_pkg::*;
#(
   parameter int NUM_AXES     = NUM_AXES_DEF,
   parameter int CALC_TIMEOUT = 16,
   parameter int IDX_W        = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_AXES-1:0]                  req,
   input  logic [NUM_AXES*CALC_W-1:0]           req_num,
   input  logic [NUM_AXES*CALC_W-1:0]           req_speed,
   input  logic [NUM_AXES*CALC_W-1:0]           req_acc,
   input  logic [NUM_AXES*CALC_W-1:0]           req_jerk,
   output logic [NUM_AXES-1:0]                  ack,
   output logic [NUM_AXES-1:0]                  err,
   output logic [NUM_PARAMS-1:0][CALC_W-1:0]    res_params,
   output logic [IDX_W-1:0]                     res_axis,
   output logic                                 busy,
   output logic                                 calc_start,
   output logic signed [CALC_W-1:0]             calc_num,
   output logic [CALC_W-1:0]                    calc_speed,
   output logic [CALC_W-1:0]                    calc_acceleration,
   output logic [CALC_W-1:0]                    calc_jerk,
   input  logic [NUM_PARAMS-1:0][CALC_W-1:0]    calc_params,
   input  logic                                 calc_finish
);

   localparam int TCNT_W = $clog2(CALC_TIMEOUT + 1);

   arb_state_t          state, next_state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [NUM_AXES-1:0] grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_vld;
   logic [NUM_AXES-1:0] owner_oh;
   logic [TCNT_W-1:0]   timeout_cnt;
   logic                timeout_hit;
   logic                ops_ok;

   rr_arbiter #(
      .NUM_AXES (NUM_AXES),
      .IDX_W    (IDX_W)
   ) u_rr (
      .req       (req),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // Operands are validated from the latched copy so the compare stays off
   // the grant mux path. A bad set spends its first BUSY cycle with start
   // held low and then leaves for REJECT, so the calculator never sees it.
   assign ops_ok = (calc_speed != '0) && (calc_acceleration != '0) &&
                   (calc_jerk != '0) && (calc_jerk <= calc_speed);
   assign timeout_hit = (timeout_cnt == TCNT_W'(CALC_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ARB_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ARB_IDLE:   if (grant_vld) next_state = ARB_BUSY;
         ARB_BUSY: begin
            if (!ops_ok)          next_state = ARB_REJECT;
            else if (calc_finish) next_state = ARB_DONE;
            else if (timeout_hit) next_state = ARB_REJECT;
         end
         ARB_DONE:   next_state = ARB_DRAIN;
         ARB_REJECT: next_state = ARB_DRAIN;
         ARB_DRAIN:  if (!calc_finish) next_state = ARB_IDLE;
         default:    next_state = ARB_IDLE;
      endcase
   end

   // Grant capture and result capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr            <= '0;
         res_axis          <= '0;
         owner_oh          <= '0;
         calc_num          <= '0;
         calc_speed        <= '0;
         calc_acceleration <= '0;
         calc_jerk         <= '0;
         res_params        <= '0;
         timeout_cnt       <= '0;
      end else begin
         if (state == ARB_IDLE && grant_vld) begin
            calc_num          <= $signed(req_num[CALC_W*grant_idx +: CALC_W]);
            calc_speed        <= req_speed[CALC_W*grant_idx +: CALC_W];
            calc_acceleration <= req_acc[CALC_W*grant_idx +: CALC_W];
            calc_jerk         <= req_jerk[CALC_W*grant_idx +: CALC_W];
            res_axis          <= grant_idx;
            owner_oh          <= grant;
            timeout_cnt       <= '0;
            rr_ptr            <= (grant_idx == IDX_W'(NUM_AXES - 1)) ? '0
                                                                    : grant_idx + 1'b1;
         end
         if (state == ARB_BUSY) begin
            timeout_cnt <= timeout_cnt + 1'b1;
            if (ops_ok && calc_finish) res_params <= calc_params;
         end
      end
   end

   // Start drops in the cycle finish is seen so the calculator gets a
   // single clean start level per job.
   always_comb begin
      busy       = (state != ARB_IDLE);
      calc_start = (state == ARB_BUSY) && ops_ok && !calc_finish;
      ack        = (state == ARB_DONE)   ? owner_oh : '0;
      err        = (state == ARB_REJECT) ? owner_oh : '0;
   end

endmodule
